// File: rtl/mult_axil_pkg.sv
// Shared types and constants for the AXI4-Lite multiplier master.
// Register map of the remote multiplier and the FSM state encoding.
package mult_axil_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD,
        S_RESP
    } state_e;

    localparam logic [7:0] OFF_A   = 8'h00;
    localparam logic [7:0] OFF_B   = 8'h04;
    localparam logic [7:0] OFF_RES = 8'h08;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/mult_axil_if.sv
// Bundle of the op/result handshakes and the AXI4-Lite master bus.
// master = the sequencer, slave = the op source, result sink and AXI slave.
interface mult_axil_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  op_valid;
    logic                  op_ready;
    logic [31:0]           op_a;
    logic [31:0]           op_b;

    logic                  res_valid;
    logic                  res_ready;
    logic [31:0]           res_data;
    logic                  res_err;

    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [2:0]            M_AXI_AWPROT;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [31:0]           M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [31:0]           M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data, res_err,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data, res_err,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/mult_axil_wr_channel.sv
// AW/W/B handshake engine for one AXI4-Lite write.
// AW and W complete independently; B is accepted only after both.
module axil_wr_channel
    import mult_axil_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       awvalid,
    input  logic       awready,
    output logic       wvalid,
    input  logic       wready,
    input  logic       bvalid,
    input  logic [1:0] bresp,
    output logic       bready,
    output logic       done,
    output logic       err,
    output logic       progress
);

    logic aw_pend_q, aw_pend_d;
    logic w_pend_q, w_pend_d;
    logic b_pend_q, b_pend_d;
    logic aw_hs, w_hs, b_hs;

    assign aw_hs = aw_pend_q & awready;
    assign w_hs  = w_pend_q & wready;
    assign b_hs  = b_pend_q & bvalid;

    assign awvalid  = aw_pend_q;
    assign wvalid   = w_pend_q;
    assign bready   = b_pend_q;
    assign done     = b_hs;
    assign err      = b_hs & resp_err(bresp);
    assign progress = aw_hs | w_hs | b_hs;

    // Track which phases are still outstanding for the current write
    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        b_pend_d  = b_pend_q;
        if (aw_hs) begin
            aw_pend_d = 1'b0;
        end
        if (w_hs) begin
            w_pend_d = 1'b0;
        end
        if ((aw_pend_q | w_pend_q) & ~aw_pend_d & ~w_pend_d) begin
            b_pend_d = 1'b1;
        end
        if (b_hs) begin
            b_pend_d = 1'b0;
        end
        if (start) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            b_pend_d  = 1'b0;
        end
        if (abort) begin
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            b_pend_d  = 1'b0;
        end
    end

    // Phase flags register
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            b_pend_q  <= 1'b0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            b_pend_q  <= b_pend_d;
        end
    end

endmodule

// File: rtl/mult_axil_master.sv
// Runs a*b on a memory-mapped multiplier over AXI4-Lite.
// Writes op_a and op_b, reads the product back, reports it with an error flag.
module mult_axil_master
    import mult_axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int C_TIMEOUT = 1024
) (
    input logic         ACLK,
    input logic         ARESET,
    mult_axil_if.master bus
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] ADDR_A   = C_BASE_ADDR + AW'(OFF_A);
    localparam logic [AW-1:0] ADDR_B   = C_BASE_ADDR + AW'(OFF_B);
    localparam logic [AW-1:0] ADDR_RES = C_BASE_ADDR + AW'(OFF_RES);
    localparam logic [3:0] STRB_ALL =
        4'((64'd1 << (C_M_AXI_DATA_WIDTH / 8)) - 64'd1);
    localparam logic [31:0] TMO_LAST = 32'(C_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        ar_pend_q, ar_pend_d;
    logic        r_pend_q, r_pend_d;
    logic [31:0] timer_q, timer_d;

    logic wr_start, wr_abort;
    logic wr_awvalid, wr_wvalid, wr_bready;
    logic wr_done, wr_err, wr_progress;
    logic ar_hs, r_hs;
    logic waiting, progress, timeout;

    axil_wr_channel u_wr (
        .clk      (ACLK),
        .rst      (ARESET),
        .start    (wr_start),
        .abort    (wr_abort),
        .awvalid  (wr_awvalid),
        .awready  (bus.M_AXI_AWREADY),
        .wvalid   (wr_wvalid),
        .wready   (bus.M_AXI_WREADY),
        .bvalid   (bus.M_AXI_BVALID),
        .bresp    (bus.M_AXI_BRESP),
        .bready   (wr_bready),
        .done     (wr_done),
        .err      (wr_err),
        .progress (wr_progress)
    );

    assign ar_hs    = ar_pend_q & bus.M_AXI_ARREADY;
    assign r_hs     = r_pend_q & bus.M_AXI_RVALID;
    assign progress = wr_progress | ar_hs | r_hs;
    assign waiting  = (state_q == S_WR_A) | (state_q == S_WR_B)
                    | (state_q == S_RD);
    assign timeout  = waiting & ~progress & (timer_q == TMO_LAST);

    // Next state, operand capture, result capture and wait timer
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        err_d     = err_q;
        ar_pend_d = ar_pend_q;
        r_pend_d  = r_pend_q;
        wr_start  = 1'b0;
        wr_abort  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    err_d    = 1'b0;
                    wr_start = 1'b1;
                    state_d  = S_WR_A;
                end
            end
            S_WR_A, S_WR_B: begin
                if (timeout) begin
                    wr_abort = 1'b1;
                    err_d    = 1'b1;
                    data_d   = '0;
                    state_d  = S_RESP;
                end else if (wr_done) begin
                    err_d = err_q | wr_err;
                    if (state_q == S_WR_A) begin
                        wr_start = 1'b1;
                        state_d  = S_WR_B;
                    end else begin
                        ar_pend_d = 1'b1;
                        state_d   = S_RD;
                    end
                end
            end
            S_RD: begin
                if (timeout) begin
                    ar_pend_d = 1'b0;
                    r_pend_d  = 1'b0;
                    err_d     = 1'b1;
                    data_d    = '0;
                    state_d   = S_RESP;
                end else begin
                    if (ar_hs) begin
                        ar_pend_d = 1'b0;
                        r_pend_d  = 1'b1;
                    end
                    if (r_hs) begin
                        r_pend_d = 1'b0;
                        data_d   = bus.M_AXI_RDATA;
                        err_d    = err_q | resp_err(bus.M_AXI_RRESP);
                        state_d  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!waiting || (state_d != state_q) || progress) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Sequencer state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            ar_pend_q <= 1'b0;
            r_pend_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            data_q    <= data_d;
            err_q     <= err_d;
            ar_pend_q <= ar_pend_d;
            r_pend_q  <= r_pend_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_RESP);
    assign bus.res_data  = data_q;
    assign bus.res_err   = err_q;

    assign bus.M_AXI_AWADDR  = (state_q == S_WR_B) ? ADDR_B : ADDR_A;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = wr_awvalid;
    assign bus.M_AXI_WDATA   = (state_q == S_WR_B) ? b_q : a_q;
    assign bus.M_AXI_WSTRB   = STRB_ALL;
    assign bus.M_AXI_WVALID  = wr_wvalid;
    assign bus.M_AXI_BREADY  = wr_bready;

    assign bus.M_AXI_ARADDR  = ADDR_RES;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = ar_pend_q;
    assign bus.M_AXI_RREADY  = r_pend_q;

endmodule

// File: tb/tb_mult_axil_master.sv
// Directed bench for mult_axil_master with a behavioural AXI4-Lite
// multiplier slave and hand-computed expected results.
module tb_mult_axil_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_axil_if #(.ADDR_WIDTH(32)) bus();

    mult_axil_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (32'h0000_0000),
        .C_TIMEOUT          (16)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // slave knobs
    int   aw_delay = 0;
    logic ar_en = 1'b1;
    logic inj_err = 1'b0;

    // slave state
    logic        aw_got, w_got, bv, rv;
    logic [31:0] aw_a, w_d, reg_a, reg_b, rd;
    logic [1:0]  br;
    int          aw_wait;
    logic [31:0] wr_addr_log [16];
    logic [31:0] wr_data_log [16];
    int          wr_cnt = 0;
    int          ar_cnt = 0;
    logic [31:0] ar_addr_last;
    int          bready_bad = 0;
    int          ar_run = 0;
    int          ar_last_run = 0;

    assign bus.M_AXI_AWREADY = (aw_wait >= aw_delay);
    assign bus.M_AXI_WREADY  = 1'b1;
    assign bus.M_AXI_ARREADY = ar_en;
    assign bus.M_AXI_BVALID  = bv;
    assign bus.M_AXI_BRESP   = br;
    assign bus.M_AXI_RVALID  = rv;
    assign bus.M_AXI_RRESP   = 2'b00;
    assign bus.M_AXI_RDATA   = rd;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural zero-wait multiplier slave
    always @(posedge clk) begin
        logic ag, wg;
        logic [31:0] aa, wd;
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; bv <= 1'b0; rv <= 1'b0;
            aw_wait <= 0; br <= 2'b00; rd <= '0;
        end else begin
            ag = aw_got; wg = w_got; aa = aw_a; wd = w_d;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                ag = 1'b1; aa = bus.M_AXI_AWADDR; aw_wait <= 0;
            end else if (bus.M_AXI_AWVALID) begin
                aw_wait <= aw_wait + 1;
            end else begin
                aw_wait <= 0;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                wg = 1'b1; wd = bus.M_AXI_WDATA;
            end
            if (bv && bus.M_AXI_BREADY) bv <= 1'b0;
            if (ag && wg) begin
                bv <= 1'b1;
                br <= (inj_err && aa == 32'h4) ? 2'b10 : 2'b00;
                if (aa == 32'h0) reg_a <= wd;
                else if (aa == 32'h4) reg_b <= wd;
                wr_addr_log[wr_cnt % 16] <= aa;
                wr_data_log[wr_cnt % 16] <= wd;
                wr_cnt <= wr_cnt + 1;
                ag = 1'b0; wg = 1'b0;
            end
            aw_got <= ag; w_got <= wg; aw_a <= aa; w_d <= wd;
            if (rv && bus.M_AXI_RREADY) rv <= 1'b0;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                rv <= 1'b1;
                rd <= reg_a * reg_b;
                ar_addr_last <= bus.M_AXI_ARADDR;
                ar_cnt <= ar_cnt + 1;
            end
        end
    end

    // protocol monitors
    always @(posedge clk) begin
        if (bus.M_AXI_BREADY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID))
            bready_bad <= bready_bad + 1;
        if (bus.M_AXI_ARVALID) begin
            ar_run <= ar_run + 1;
        end else begin
            if (ar_run != 0) ar_last_run <= ar_run;
            ar_run <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] axi_act();
        return {27'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            output int t0);
        int n;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b;
        n = 0;
        while (!bus.op_ready && n < 50) begin
            @(negedge clk); n++;
        end
        check("op accepted", 32'(bus.op_ready), 32'd1);
        t0 = cyc;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic wait_res(input int t0, output logic [31:0] d,
                            output logic e, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 400) begin
            @(negedge clk); n++;
        end
        check("res_valid seen", 32'(bus.res_valid), 32'd1);
        lat = cyc - t0;
        d = bus.res_data;
        e = bus.res_err;
    endtask

    task automatic ack_res();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic e,
                         output int lat);
        int t0;
        start_op(a, b, t0);
        wait_res(t0, d, e, lat);
        ack_res();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs [5];
        logic [31:0] d;
        logic e;
        int lat, t0, wc0, ac0, bb0, bad, n;

        vecs[0] = '{32'd3, 32'd5, 32'd15, 1'b0, 7};
        vecs[1] = '{32'd0, 32'd0, 32'd0, 1'b0, 7};
        vecs[2] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 7};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 7};
        vecs[4] = '{32'h1234, 32'h100, 32'h0012_3400, 1'b0, 7};

        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.res_ready = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst axi idle", axi_act(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst op_ready", 32'(bus.op_ready), 32'd1);
        check("rst axi after", axi_act(), 32'd0);
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst res_err", 32'(bus.res_err), 32'd0);
        check("rst res_data", bus.res_data, 32'd0);
        check("rst prot/strb",
              {21'd0, bus.M_AXI_AWPROT, bus.M_AXI_ARPROT, 1'b0, bus.M_AXI_WSTRB},
              32'h0000_000F);

        // table of zero-wait ops
        for (int i = 0; i < 5; i++) begin
            wc0 = wr_cnt; ac0 = ar_cnt;
            do_op(vecs[i].a, vecs[i].b, d, e, lat);
            check("vec data", d, vecs[i].exp_d);
            check("vec err", 32'(e), 32'(vecs[i].exp_e));
            check("vec latency", 32'(lat), 32'(vecs[i].exp_lat));
            check("vec writes", 32'(wr_cnt - wc0), 32'd2);
            check("vec wr0 addr", wr_addr_log[wc0 % 16], 32'h0);
            check("vec wr0 data", wr_data_log[wc0 % 16], vecs[i].a);
            check("vec wr1 addr", wr_addr_log[(wc0 + 1) % 16], 32'h4);
            check("vec wr1 data", wr_data_log[(wc0 + 1) % 16], vecs[i].b);
            check("vec reads", 32'(ar_cnt - ac0), 32'd1);
            check("vec rd addr", ar_addr_last, 32'h8);
        end

        // W accepted three cycles before AW
        aw_delay = 3;
        wc0 = wr_cnt; bb0 = bready_bad;
        do_op(32'h0000_FFFF, 32'h0001_0001, d, e, lat);
        check("skew data", d, 32'hFFFF_FFFF);
        check("skew err", 32'(e), 32'd0);
        check("skew latency", 32'(lat), 32'd13);
        check("skew writes", 32'(wr_cnt - wc0), 32'd2);
        check("skew wr0 data", wr_data_log[wc0 % 16], 32'h0000_FFFF);
        check("skew wr1 data", wr_data_log[(wc0 + 1) % 16], 32'h0001_0001);
        check("skew early bready", 32'(bready_bad - bb0), 32'd0);
        aw_delay = 0;

        // SLVERR on the op_b write, then a clean op
        inj_err = 1'b1;
        ac0 = ar_cnt;
        do_op(32'd2, 32'd2, d, e, lat);
        check("slverr err", 32'(e), 32'd1);
        check("slverr read issued", 32'(ar_cnt - ac0), 32'd1);
        check("slverr data", d, 32'd4);
        inj_err = 1'b0;
        do_op(32'd4, 32'd4, d, e, lat);
        check("after err data", d, 32'd16);
        check("after err err", 32'(e), 32'd0);

        // result held 10 cycles, then op_valid during the result handshake
        start_op(32'd6, 32'd7, t0);
        wait_res(t0, d, e, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_data !== d || bus.res_err !== e
                || bus.op_ready)
                bad++;
        end
        check("hold stable", 32'(bad), 32'd0);
        check("hold data", d, 32'd42);
        bus.res_ready = 1'b1;
        bus.op_valid = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd9;
        check("no accept in resp", 32'(bus.op_ready), 32'd0);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("bubble op_ready", 32'(bus.op_ready), 32'd1);
        check("bubble res_valid", 32'(bus.res_valid), 32'd0);
        t0 = cyc;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        wait_res(t0, d, e, lat);
        check("bubble data", d, 32'd18);
        check("bubble latency", 32'(lat), 32'd7);
        ack_res();

        // slave never accepts AR
        ar_en = 1'b0;
        start_op(32'd9, 32'd9, t0);
        wait_res(t0, d, e, lat);
        check("tmo err", 32'(e), 32'd1);
        check("tmo data", d, 32'd0);
        check("tmo axi idle", axi_act(), 32'd0);
        ack_res();
        check("tmo arvalid run", 32'(ar_last_run), 32'd16);
        ar_en = 1'b1;
        do_op(32'd3, 32'd4, d, e, lat);
        check("tmo recover data", d, 32'd12);
        check("tmo recover err", 32'(e), 32'd0);

        // reset pulse while the op_b write is in flight
        start_op(32'd3, 32'd3, t0);
        n = 0;
        @(negedge clk);
        while (!(bus.M_AXI_AWVALID && bus.M_AXI_AWADDR == 32'h4) && n < 40) begin
            @(negedge clk); n++;
        end
        check("reached wr_b", 32'(bus.M_AXI_AWVALID), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst axi", axi_act(), 32'd0);
        check("midrst res_valid", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst op_ready", 32'(bus.op_ready), 32'd1);
        check("midrst no result", 32'(bus.res_valid), 32'd0);
        do_op(32'd5, 32'd5, d, e, lat);
        check("post rst data", d, 32'd25);
        check("post rst latency", 32'(lat), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
